// File: rtl/sum_accumulator.sv
// Batch accumulator for adder sums: collects COUNT samples per batch over valid/ready,
// then holds total, average, maximum and a saturation flag until the sink accepts them.
module sum_accumulator #(
    parameter int IN_W       = 5,
    parameter int LOG2_COUNT = 3,
    parameter int ACC_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       S_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      total,
    output logic [ACC_W-1:0]      avg,
    output logic [IN_W-1:0]       max_sum,
    output logic                  ovf,
    output logic [LOG2_COUNT-1:0] count
);

    typedef enum logic {ACCUM, HOLD} state_e;

    // COUNT is a power of two, so the last sample index is all ones.
    localparam logic [LOG2_COUNT-1:0] LAST_IDX = '1;

    state_e                state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [LOG2_COUNT-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]       max_q, max_d;
    logic                  bovf_q, bovf_d;
    logic                  out_valid_q, out_valid_d;
    logic [ACC_W-1:0]      total_q, total_d;
    logic [ACC_W-1:0]      avg_q, avg_d;
    logic [IN_W-1:0]       max_sum_q, max_sum_d;
    logic                  ovf_q, ovf_d;

    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_sat;
    logic             bovf_next;
    logic [IN_W-1:0]  max_next;
    logic             xfer;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        sum_wide  = {1'b0, acc_q} + (ACC_W+1)'(S_in);
        acc_sat   = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
        bovf_next = bovf_q | sum_wide[ACC_W];
        max_next  = (S_in > max_q) ? S_in : max_q;
        xfer      = in_valid && (state_q == ACCUM);

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        bovf_d      = bovf_q;
        out_valid_d = out_valid_q;
        total_d     = total_q;
        avg_d       = avg_q;
        max_sum_d   = max_sum_q;
        ovf_d       = ovf_q;

        if (clear) begin
            // Pending result is dropped but the last reported values remain visible.
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            max_d       = '0;
            bovf_d      = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (xfer) begin
                        if (cnt_q == LAST_IDX) begin
                            total_d     = acc_sat;
                            avg_d       = acc_sat >> LOG2_COUNT;
                            max_sum_d   = max_next;
                            ovf_d       = bovf_next;
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                            acc_d       = '0;
                            cnt_d       = '0;
                            max_d       = '0;
                            bovf_d      = 1'b0;
                        end else begin
                            acc_d  = acc_sat;
                            cnt_d  = cnt_q + 1'b1;
                            max_d  = max_next;
                            bovf_d = bovf_next;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            max_q       <= '0;
            bovf_q      <= 1'b0;
            out_valid_q <= 1'b0;
            total_q     <= '0;
            avg_q       <= '0;
            max_sum_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            bovf_q      <= bovf_d;
            out_valid_q <= out_valid_d;
            total_q     <= total_d;
            avg_q       <= avg_d;
            max_sum_q   <= max_sum_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign total     = total_q;
    assign avg       = avg_q;
    assign max_sum   = max_sum_q;
    assign ovf       = ovf_q;
    assign count     = cnt_q;

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
Downstream consumer of the 4-bit adder's 5-bit sum S.
- Accepts one sum per valid/ready handshake and accumulates batches of COUNT sums.
- Reports the batch total, the average and the maximum sum, plus a saturation flag, through a held valid/ready output.
- Sits between the adder datapath and any result sink or display logic.

Parameters:
IN_W, 5, width of incoming sum (matches adder output width)
LOG2_COUNT, 3, log2 of samples per batch; COUNT = 2**LOG2_COUNT (default 8)
ACC_W, 8, accumulator/total width; must be >= IN_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
clear  input  1  synchronous discard of partial batch/pending result
in_valid  input  1  S_in valid
in_ready  output  1  block can accept S_in
S_in  input  IN_W  sum from adder, unsigned
out_valid  output  1  batch result valid
out_ready  input  1  sink accepts result
total  output  ACC_W  saturated batch sum
avg  output  ACC_W  total >> LOG2_COUNT, zero-extended
max_sum  output  IN_W  largest S_in in batch
ovf  output  1  accumulator saturated during batch
count  output  LOG2_COUNT  samples accepted in current batch

Behaviour:
- States: ACCUM, HOLD. Reset state is ACCUM.
- Reset (rst=1 at clk edge) has highest priority and applies in any state, including mid-batch or mid-HOLD:
  - Next state ACCUM.
  - Internal acc, cnt, running max and ovf cleared.
  - Outputs: out_valid=0, total=0, avg=0, max_sum=0, ovf=0, count=0.
- in_ready is combinational, equal to (state==ACCUM). All other outputs are registered.
- Transfer occurs when in_valid && in_ready.
- ACCUM, per transfer:
  - acc_next = acc + zero-extended S_in. If the true sum exceeds 2^ACC_W-1, acc_next = all ones and the batch ovf flag sets (sticky for the batch).
  - Running max updates when S_in > max.
  - cnt increments.
  - count output shows accepted samples in the batch, 0..COUNT-1.
- Batch completion, on the transfer with cnt==COUNT-1:
  - Next edge loads total=acc_next, avg=acc_next>>LOG2_COUNT, max_sum=updated max, ovf=batch flag.
  - out_valid=1; state goes to HOLD.
  - Internal acc, cnt and max clear; count=0.
  - Latency: out_valid rises the cycle after the COUNT-th transfer.
- HOLD:
  - in_ready=0; S_in and in_valid are ignored.
  - total, avg, max_sum and ovf stay stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: out_valid=0 next edge and state returns to ACCUM.
  - Result outputs keep their last values until the next batch completes.
- clear (lower priority than rst; any state):
  - Next state ACCUM; internal acc, cnt, max and batch flag cleared; count=0; out_valid=0, so any pending result is dropped.
  - Result outputs are not zeroed.
  - A transfer in the same cycle as clear is discarded.
- No back-to-back acceptance across a batch boundary: the first sample of the next batch is accepted no earlier than the cycle after out_valid falls.
- With defaults, the maximum total is 8*30 = 240, so it fits ACC_W=8 and ovf cannot assert. Saturation is reachable only with a reduced ACC_W.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1, S_in=7 -> in_ready=1, out_valid=0, total=0, avg=0, max_sum=0, ovf=0, count=0. No sample is counted.
2. Full batch: 8 consecutive transfers S_in=0,2,5,9,13,17,21,29 with out_ready=0.
   - out_valid=1 the cycle after the 8th transfer, with total=96, avg=12, max_sum=29, ovf=0, count=0.
   - in_ready=0 while in HOLD.
3. Backpressure: continue case 2 with out_ready=0 for 10 cycles and in_valid=1, S_in=3.
   - Outputs stay unchanged and no sample is accepted.
   - Then out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 next cycle; total stays 96.
4. Bubbles: in_valid toggled 1,0,1,0,... with S_in=30 on the valid cycles -> only handshaked samples count. After 8 transfers: total=240, avg=30, max_sum=30.
5. Saturation (ACC_W=6): 8 samples of 30 -> acc saturates at 63 on the 3rd transfer, giving total=63, avg=7, ovf=1. The next batch of 8 samples of 1 gives ovf=0 and total=8.
6. clear/rst mid-operation:
   - 3 samples of 10, then clear asserted concurrently with a transfer of S_in=10, then 8 samples of 1 -> total=8, max_sum=1.
   - Separately, rst asserted during HOLD -> out_valid=0 and total=0 next cycle.
